// File: rtl/epd_spi_tx_if.sv
// Byte handshake between an upstream sequencer and the e-ink SPI transmitter.
// The sequencer offers a byte with tx_valid. The transmitter takes it when
// tx_ready is also high, and later reports the end of the frame with a
// one-cycle tx_done pulse.
interface epd_spi_tx_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_done;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_dc,
        input  tx_ready,
        input  tx_done
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_dc,
        output tx_ready,
        output tx_done
    );
endinterface

// File: rtl/epd_spi_tx.sv
// Serial byte transmitter for the e-ink panel's SPI command/data port.
// Bit timing is set by a half-period tick counter that runs on clk_in, so
// SCLK is an ordinary registered output and is never used as a clock.
// Frames are SPI mode 0 and send MSB first. DC is latched at accept time.
// A new byte is only accepted while the panel's BUSY line is low.
module epd_spi_tx #(
    parameter int IN_CLK  = 50,
    parameter int SPI_CLK = 1000
) (
    input  logic          clk_in,
    input  logic          rst_n,
    epd_spi_tx_if.slave   tx,
    input  logic          busy_in,
    output logic          epd_cs_n,
    output logic          epd_sclk,
    output logic          epd_mosi,
    output logic          epd_dc
);

    localparam int HALF  = (IN_CLK * 1000) / (SPI_CLK * 2) - 1;
    localparam int CNT_W = $clog2(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [6:0]       shreg, shreg_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             dc_q, dc_d;
    logic             done_q, done_d;
    logic             busy_meta, busy_s;
    logic             ready;
    logic             accept;
    logic             phase_end;

    assign ready     = (state == IDLE) && !busy_s;
    assign accept    = tx.tx_valid && ready;
    assign phase_end = (cnt == CNT_LAST);

    assign tx.tx_ready = ready;
    assign tx.tx_done  = done_q;
    assign epd_cs_n    = cs_n_q;
    assign epd_sclk    = sclk_q;
    assign epd_mosi    = mosi_q;
    assign epd_dc      = dc_q;

    // Two-flop synchroniser for BUSY. It resets to "busy" so that no byte is accepted until a clean low has been seen.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta <= 1'b1;
            busy_s    <= 1'b1;
        end else begin
            busy_meta <= busy_in;
            busy_s    <= busy_meta;
        end
    end

    // State register plus the registered pin values. Reset drops any frame in progress and forces the pins idle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 7'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shreg   <= shreg_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next pin values. MOSI advances on the HIGH->LOW move, which is the falling SCLK edge, so it is stable for the panel's rising-edge sample.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        shreg_d = shreg;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    shreg_d = tx.tx_data[6:0];
                    mosi_d  = tx.tx_data[7];
                    dc_d    = tx.tx_dc;
                    cs_n_d  = 1'b0;
                end
            end

            SETUP: begin
                if (phase_end) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            HIGH: begin
                if (phase_end) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    if (bit_idx != 3'd0) begin
                        mosi_d  = shreg[6];
                        shreg_d = {shreg[5:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            LOW: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (bit_idx != 3'd0) begin
                        bit_d   = bit_idx - 3'd1;
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_epd_spi_tx.sv
// Bench for epd_spi_tx. Two instances are built:
//  - A runs with a fast SCLK (HALF=4, H=5) and is checked on every cycle
//    against a frame-timing model.
//  - B uses the default parameters (H=25).
module tb_epd_spi_tx;

    localparam int HA = 5;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic busy_in = 1'b0;
    logic busy_b  = 1'b0;
    logic cs_a, sclk_a, mosi_a, dc_a;
    logic cs_b, sclk_b, mosi_b, dc_b;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    epd_spi_tx_if bus_a ();
    epd_spi_tx_if bus_b ();

    epd_spi_tx #(.IN_CLK(50), .SPI_CLK(5000)) dut_a (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .tx      (bus_a.slave),
        .busy_in (busy_in),
        .epd_cs_n(cs_a),
        .epd_sclk(sclk_a),
        .epd_mosi(mosi_a),
        .epd_dc  (dc_a)
    );

    epd_spi_tx dut_b (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .tx      (bus_b.slave),
        .busy_in (busy_b),
        .epd_cs_n(cs_b),
        .epd_sclk(sclk_b),
        .epd_mosi(mosi_b),
        .epd_dc  (dc_b)
    );

    // Free-running 100 MHz clock.
    always #5 clk_in = ~clk_in;

    // Cycle number as seen at each negedge.
    always @(posedge clk_in) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference model for instance A.
    // A frame accepted in cycle T occupies cycles T+1 .. T+17H as 17 phases of H cycles each:
    //  - phase 0 is setup;
    //  - odd phases are SCLK high;
    //  - during phase p, MOSI carries bit 7-min(7,p/2).
    // Cycle T+17H+1 is the tx_done cycle.
    bit         mActive = 1'b0;
    int         mT = 0;
    logic [7:0] mByte = 8'h00;
    logic       mDc = 1'b0;
    logic       mMosiLast = 1'b0;
    logic       mDcLast = 1'b0;
    logic       mMeta = 1'b1;
    logic       mSync = 1'b1;

    always @(negedge clk_in) begin
        logic [5:0] expv;
        logic [5:0] gotv;
        logic       eCs, eSclk, eMosi, eDc, eDone, eReady;
        int         t, p, idx;
        bit         ending;
        gotv = {cs_a, sclk_a, mosi_a, dc_a, bus_a.tx_done, bus_a.tx_ready};
        if (!rst_n) begin
            expv = 6'b100000;
            checkOutput($sformatf("outputs_in_reset@%0d", cycle), int'(gotv), int'(expv));
            mActive   = 1'b0;
            mMosiLast = 1'b0;
            mDcLast   = 1'b0;
            mMeta     = 1'b1;
            mSync     = 1'b1;
        end else begin
            eCs = 1'b1; eSclk = 1'b0; eMosi = mMosiLast; eDc = mDcLast;
            eDone = 1'b0; eReady = !mActive && !mSync;
            ending = 1'b0;
            t = 0;
            if (mActive) begin
                t = cycle - mT;
                if (t <= 17 * HA) begin
                    p      = (t - 1) / HA;
                    idx    = (p / 2 > 7) ? 0 : 7 - p / 2;
                    eCs    = 1'b0;
                    eSclk  = (p % 2) == 1;
                    eMosi  = mByte[idx];
                    eDc    = mDc;
                    eReady = 1'b0;
                end else begin
                    eDone  = 1'b1;
                    eMosi  = mByte[0];
                    eDc    = mDc;
                    eReady = !mSync;
                    ending = 1'b1;
                end
            end
            expv = {eCs, eSclk, eMosi, eDc, eDone, eReady};
            checkOutput($sformatf("outputs@%0d", cycle), int'(gotv), int'(expv));
            mMosiLast = eMosi;
            mDcLast   = eDc;
            if (ending) mActive = 1'b0;
            if (!mActive && eReady && bus_a.tx_valid) begin
                mActive = 1'b1;
                mT      = cycle;
                mByte   = bus_a.tx_data;
                mDc     = bus_a.tx_dc;
            end
            mSync = mMeta;
            mMeta = busy_in;
        end
    end

    // Offer one byte to A and wait (bounded) for it to be taken.
    // The task returns at posedge+1 of the cycle after the accept.
    task automatic applyStimulus(input logic [7:0] data, input logic dc, output int acceptCycle);
        bit ok;
        ok = 1'b0;
        acceptCycle = -1;
        @(posedge clk_in); #1;
        bus_a.tx_data  = data;
        bus_a.tx_dc    = dc;
        bus_a.tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (bus_a.tx_ready) begin
                acceptCycle = cycle;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_in); #1;
        bus_a.tx_valid = 1'b0;
        if (!ok) checkOutput("accept_timeout", 0, 1);
    endtask

    // Watch one frame on A. Records bits at SCLK rises, cs_n low cycles, the rise count and the tx_done offset.
    task automatic captureFrame(input int acceptCycle, output logic [7:0] bits,
                                output int csLow, output int rises, output int doneOffset);
        logic prevSclk;
        prevSclk = 1'b0;
        bits = 8'h00; csLow = 0; rises = 0; doneOffset = -1;
        for (int i = 0; i < 40 * HA; i++) begin
            @(negedge clk_in);
            if (!cs_a) csLow++;
            if (sclk_a && !prevSclk) begin
                rises++;
                bits = {bits[6:0], mosi_a};
            end
            prevSclk = sclk_a;
            if (bus_a.tx_done) begin
                doneOffset = cycle - acceptCycle;
                break;
            end
        end
    endtask

    task automatic checkReleaseReady();
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        @(negedge clk_in);
        checkOutput("ready_after_release_0", int'(bus_a.tx_ready), 0);
        @(negedge clk_in);
        checkOutput("ready_after_release_1", int'(bus_a.tx_ready), 0);
        @(negedge clk_in);
        checkOutput("ready_after_release_2", int'(bus_a.tx_ready), 1);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int         tAcc, csLow, rises, doneOff, waited;
        logic [7:0] bits, data;
        logic [15:0] bits16;
        logic       dc, prevS;
        int         doneCnt, csHigh, firstHigh, firstLow, run;
        bit         busyDuring, sawFall;

        bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00; bus_a.tx_dc = 1'b0;
        bus_b.tx_valid = 1'b0; bus_b.tx_data = 8'h00; bus_b.tx_dc = 1'b0;

        // Reset state and the ready delay after release.
        repeat (3) @(negedge clk_in);
        checkOutput("reset_pins", int'({cs_a, sclk_a, mosi_a, dc_a, bus_a.tx_done}), 5'b10000);
        checkOutput("reset_ready", int'(bus_a.tx_ready), 0);
        checkReleaseReady();

        // Single data byte 0xA5.
        $display("[TB] single byte 0xA5");
        applyStimulus(8'hA5, 1'b1, tAcc);
        captureFrame(tAcc, bits, csLow, rises, doneOff);
        checkOutput("a5_bits", int'(bits), 8'hA5);
        checkOutput("a5_rises", rises, 8);
        checkOutput("a5_cs_low", csLow, 85);
        checkOutput("a5_done_offset", doneOff, 86);
        checkOutput("a5_dc_held", int'(dc_a), 1);

        // Command byte; the inputs are changed after accept.
        $display("[TB] command byte 0x12");
        applyStimulus(8'h12, 1'b0, tAcc);
        bus_a.tx_data = 8'hFF;
        bus_a.tx_dc   = 1'b1;
        captureFrame(tAcc, bits, csLow, rises, doneOff);
        checkOutput("cmd_bits", int'(bits), 8'h12);
        checkOutput("cmd_dc", int'(dc_a), 0);

        // BUSY hold-off, then release.
        $display("[TB] busy hold-off");
        @(posedge clk_in); #1;
        busy_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        bus_a.tx_data = 8'hC3; bus_a.tx_dc = 1'b1; bus_a.tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (i % 3 == 0)
                checkOutput("busy_holdoff", int'({bus_a.tx_ready, cs_a}), 2'b01);
        end
        @(posedge clk_in); #1;
        busy_in = 1'b0;
        waited = 99;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_in);
            if (bus_a.tx_ready) begin
                waited = i;
                tAcc = cycle;
                break;
            end
        end
        checkOutput("busy_release_latency", waited, 3);
        @(posedge clk_in); #1;
        bus_a.tx_valid = 1'b0;
        captureFrame(tAcc, bits, csLow, rises, doneOff);
        checkOutput("busy_frame_bits", int'(bits), 8'hC3);

        // Back-to-back 0xFF then 0x00 with tx_valid held high.
        $display("[TB] back-to-back");
        applyStimulus(8'hFF, 1'b1, tAcc);
        bus_a.tx_valid = 1'b1;
        bus_a.tx_data  = 8'h00;
        bus_a.tx_dc    = 1'b0;
        doneCnt = 0; csHigh = 0; rises = 0; bits16 = 16'h0; prevS = 1'b0;
        for (int i = 0; i < 80 * HA && doneCnt < 2; i++) begin
            @(negedge clk_in);
            if (sclk_a && !prevS) begin
                rises++;
                bits16 = {bits16[14:0], mosi_a};
            end
            prevS = sclk_a;
            if (bus_a.tx_done) doneCnt++;
            if (cs_a && doneCnt < 2) csHigh++;
            if (bus_a.tx_done && doneCnt == 1) begin
                @(posedge clk_in); #1;
                bus_a.tx_valid = 1'b0;
            end
        end
        bus_a.tx_valid = 1'b0;
        checkOutput("b2b_done_count", doneCnt, 2);
        checkOutput("b2b_rises", rises, 16);
        checkOutput("b2b_bits", int'(bits16), 16'hFF00);
        checkOutput("b2b_cs_gap", csHigh, 1);

        // Reset in the middle of a frame.
        $display("[TB] reset mid-frame");
        applyStimulus(8'hE7, 1'b1, tAcc);
        rises = 0; prevS = 1'b0;
        for (int i = 0; i < 20 * HA && rises < 3; i++) begin
            @(negedge clk_in);
            if (sclk_a && !prevS) rises++;
            prevS = sclk_a;
        end
        checkOutput("midreset_reached_rise3", rises, 3);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_pins", int'({cs_a, sclk_a, mosi_a, dc_a, bus_a.tx_done}), 5'b10000);
        repeat (4) @(negedge clk_in);
        checkOutput("midreset_no_done", int'(bus_a.tx_done), 0);
        checkReleaseReady();
        applyStimulus(8'h81, 1'b0, tAcc);
        captureFrame(tAcc, bits, csLow, rises, doneOff);
        checkOutput("after_reset_bits", int'(bits), 8'h81);
        checkOutput("after_reset_done_offset", doneOff, 86);

        // Randomised bytes, gaps, and BUSY raised during some frames.
        $display("[TB] random traffic");
        for (int n = 0; n < 12; n++) begin
            data = 8'($urandom);
            dc   = 1'($urandom_range(0, 1));
            busyDuring = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 4)) @(posedge clk_in);
            applyStimulus(data, dc, tAcc);
            if (busyDuring) busy_in = 1'b1;
            captureFrame(tAcc, bits, csLow, rises, doneOff);
            checkOutput($sformatf("rand%0d_bits", n), int'(bits), int'(data));
            checkOutput($sformatf("rand%0d_cs_low", n), csLow, 17 * HA);
            @(posedge clk_in); #1;
            busy_in = 1'b0;
        end

        // Default parameters on instance B: byte 0x3C.
        $display("[TB] default parameters 0x3C");
        @(posedge clk_in); #1;
        bus_b.tx_data = 8'h3C; bus_b.tx_dc = 1'b1; bus_b.tx_valid = 1'b1;
        tAcc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus_b.tx_ready) begin
                tAcc = cycle;
                break;
            end
        end
        checkOutput("b_accepted", int'(tAcc >= 0), 1);
        @(posedge clk_in); #1;
        bus_b.tx_valid = 1'b0;
        csLow = 0; rises = 0; bits = 8'h00; doneOff = -1; prevS = 1'b0;
        firstHigh = -1; firstLow = -1; run = 0; sawFall = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_in);
            if (!cs_b) csLow++;
            if (sclk_b != prevS) begin
                if (prevS && firstHigh < 0) firstHigh = run;
                if (!prevS && sawFall && firstLow < 0) firstLow = run;
                if (prevS) sawFall = 1'b1;
                if (sclk_b) begin
                    rises++;
                    bits = {bits[6:0], mosi_b};
                end
                run = 0;
            end
            run++;
            prevS = sclk_b;
            if (bus_b.tx_done) begin
                doneOff = cycle - tAcc;
                break;
            end
        end
        checkOutput("b_bits", int'(bits), 8'h3C);
        checkOutput("b_high_phase", firstHigh, 25);
        checkOutput("b_low_phase", firstLow, 25);
        checkOutput("b_cs_low", csLow, 425);
        checkOutput("b_done_offset", doneOff, 426);

        repeat (5) @(posedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
